// File: rtl/fi_sched_pkg.sv
// Shared types and constants for the fault-injection campaign scheduler.
package fi_sched_pkg;

  localparam int NUM_TARGETS_DEFAULT = 3;
  localparam int TIMEOUT_W_DEFAULT   = 16;

  // Target index of each safety monitor in the mask / flag vectors.
  localparam int TGT_LOCKSTEP = 0;
  localparam int TGT_ECC      = 1;
  localparam int TGT_WATCHDOG = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_INJECT,
    ST_WAIT_DET,
    ST_CLEAR,
    ST_NEXT,
    ST_DONE
  } fi_state_e;

endpackage

// File: rtl/fi_sched_lsb_find.sv
// Combinational lowest-set-bit finder used to pick the next campaign target.
module fi_sched_lsb_find
  import fi_sched_pkg::*;
#(
  parameter int WIDTH = NUM_TARGETS_DEFAULT,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fi_campaign_scheduler.sv
// Fault-injection self-test campaign sequencer: one injection per selected
// target, a bounded detect window, a flag clear, and a sticky per-target verdict.
module fi_campaign_scheduler
  import fi_sched_pkg::*;
#(
  parameter int NUM_TARGETS = NUM_TARGETS_DEFAULT,
  parameter int TIMEOUT_W   = TIMEOUT_W_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [NUM_TARGETS-1:0] target_mask_i,
  input  logic [TIMEOUT_W-1:0]   timeout_i,
  output logic                   inj_req_o,
  output logic [NUM_TARGETS-1:0] inj_sel_o,
  input  logic                   inj_ack_i,
  input  logic [NUM_TARGETS-1:0] err_detect_i,
  output logic                   clr_err_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [NUM_TARGETS-1:0] fail_vec_o,
  output logic                   spurious_o,
  output logic                   aborted_o
);

  localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  fi_state_e state_q, state_d;

  logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   window_q, window_d;
  logic [TIMEOUT_W-1:0]   window_eff;
  logic [TIMEOUT_W-1:0]   cnt_dec;
  logic                   cnt_last;
  logic [NUM_TARGETS-1:0] remaining_q, remaining_d;
  logic [NUM_TARGETS-1:0] fail_q, fail_d;
  logic [NUM_TARGETS-1:0] cur_onehot;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       lsb_idx;
  logic                   lsb_valid;
  logic                   spurious_q, spurious_d;
  logic                   aborted_q, aborted_d;
  logic                   in_campaign;

  fi_sched_lsb_find #(
    .WIDTH (NUM_TARGETS),
    .IDX_W (IDX_W)
  ) u_lsb_find (
    .vec   (remaining_q),
    .idx   (lsb_idx),
    .valid (lsb_valid)
  );

  // A zero window would never let a target finish, so it behaves like one cycle.
  assign window_eff  = (timeout_i == '0) ? TIMEOUT_W'(1) : timeout_i;
  assign cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - TIMEOUT_W'(1);
  assign cnt_last    = (cnt_q <= TIMEOUT_W'(1));
  assign cur_onehot  = NUM_TARGETS'(1) << cur_q;
  assign in_campaign = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, shared window counter, target bookkeeping and sticky verdicts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    window_d    = window_q;
    remaining_d = remaining_q;
    cur_d       = cur_q;
    fail_d      = fail_q;
    spurious_d  = spurious_q;
    aborted_d   = aborted_q;

    if (in_campaign && abort_i) begin
      state_d   = ST_DONE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            remaining_d = target_mask_i;
            window_d    = window_eff;
            fail_d      = '0;
            spurious_d  = 1'b0;
            aborted_d   = 1'b0;
            state_d     = ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (lsb_valid) begin
            cur_d   = lsb_idx;
            cnt_d   = window_q;
            state_d = ST_INJECT;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_INJECT: begin
          if (inj_ack_i) begin
            cnt_d   = window_q;
            state_d = ST_WAIT_DET;
          end else if (cnt_last) begin
            fail_d  = fail_q | cur_onehot;
            cnt_d   = window_q;
            state_d = ST_CLEAR;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        ST_WAIT_DET: begin
          if ((err_detect_i & ~cur_onehot) != '0) begin
            spurious_d = 1'b1;
          end
          if ((err_detect_i & cur_onehot) != '0) begin
            cnt_d   = window_q;
            state_d = ST_CLEAR;
          end else if (cnt_last) begin
            fail_d  = fail_q | cur_onehot;
            cnt_d   = window_q;
            state_d = ST_CLEAR;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        ST_CLEAR: begin
          if (err_detect_i == '0) begin
            state_d = ST_NEXT;
          end else if (cnt_last) begin
            fail_d  = fail_q | cur_onehot;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_dec;
          end
        end
        ST_NEXT: begin
          remaining_d = remaining_q & ~cur_onehot;
          state_d     = ST_SELECT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      window_q    <= '0;
      remaining_q <= '0;
      cur_q       <= '0;
      fail_q      <= '0;
      spurious_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      window_q    <= window_d;
      remaining_q <= remaining_d;
      cur_q       <= cur_d;
      fail_q      <= fail_d;
      spurious_q  <= spurious_d;
      aborted_q   <= aborted_d;
    end
  end

  assign inj_req_o  = (state_q == ST_INJECT);
  assign inj_sel_o  = inj_req_o ? cur_onehot : '0;
  assign clr_err_o  = (state_q == ST_CLEAR);
  assign busy_o     = in_campaign;
  assign done_o     = (state_q == ST_DONE);
  assign pass_o     = done_o && (fail_q == '0) && !aborted_q;
  assign fail_vec_o = fail_q;
  assign spurious_o = spurious_q;
  assign aborted_o  = aborted_q;

endmodule

// File: tb/tb_fi_campaign_scheduler.sv
// Self-checking bench: a cycle-level monitor/injector responder drives the DUT,
// and a campaign-level model predicts verdicts and the done cycle.
module tb_fi_campaign_scheduler;
  import fi_sched_pkg::*;

  localparam int NT = 3;
  localparam int TW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          abort_i;
  logic [NT-1:0] target_mask_i;
  logic [TW-1:0] timeout_i;
  logic          inj_req_o;
  logic [NT-1:0] inj_sel_o;
  logic          inj_ack_i;
  logic [NT-1:0] err_detect_i;
  logic          clr_err_o;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic [NT-1:0] fail_vec_o;
  logic          spurious_o;
  logic          aborted_o;

  always #5 clk_i = ~clk_i;

  fi_campaign_scheduler #(.NUM_TARGETS(NT), .TIMEOUT_W(TW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .target_mask_i (target_mask_i),
    .timeout_i     (timeout_i),
    .inj_req_o     (inj_req_o),
    .inj_sel_o     (inj_sel_o),
    .inj_ack_i     (inj_ack_i),
    .err_detect_i  (err_detect_i),
    .clr_err_o     (clr_err_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .fail_vec_o    (fail_vec_o),
    .spurious_o    (spurious_o),
    .aborted_o     (aborted_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  // Responder behaviour per target: -1 means never.
  int ack_lat [NT];
  int det_lat [NT];
  int clr_lat [NT];
  bit spur_en [NT];
  int abort_tgt;
  int glitch_cyc;

  // Responder state and observations.
  logic [NT-1:0] flags;
  bit waiting;
  int wcnt, req_cnt, clr_cnt, cur_t;
  int done_cyc, abort_cyc, sel_errs;
  int req_cycles [NT];
  int order [$];

  // Model predictions.
  logic [NT-1:0] exp_fail;
  bit exp_spur;
  int exp_done;
  int exp_inj [NT];
  int exp_order [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_inj_req"}, 32'(inj_req_o), 0);
    checkOutput({tag, "_inj_sel"}, 32'(inj_sel_o), 0);
    checkOutput({tag, "_clr_err"}, 32'(clr_err_o), 0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 0);
    checkOutput({tag, "_done"}, 32'(done_o), 0);
    checkOutput({tag, "_pass"}, 32'(pass_o), 0);
    checkOutput({tag, "_fail_vec"}, 32'(fail_vec_o), 0);
    checkOutput({tag, "_spurious"}, 32'(spurious_o), 0);
    checkOutput({tag, "_aborted"}, 32'(aborted_o), 0);
  endtask

  task automatic setAll(input int a, input int d, input int c);
    for (int t = 0; t < NT; t++) begin
      ack_lat[t] = a;
      det_lat[t] = d;
      clr_lat[t] = c;
      spur_en[t] = 1'b0;
    end
    abort_tgt  = -1;
    glitch_cyc = -1;
  endtask

  function automatic int selIdx(input logic [NT-1:0] s);
    for (int t = 0; t < NT; t++) if (s[t]) return t;
    return -1;
  endfunction

  // Campaign-level prediction: walk the selected targets in ascending order and
  // add up the phase lengths each one spends, stopping early on a stuck clear.
  task automatic modelCampaign(input logic [NT-1:0] mask, input int tmo);
    int w, cursor, inj, wt, cl;
    bit ack_ok, det_ok, spur, stuck;
    w = (tmo == 0) ? 1 : tmo;
    cursor = 1;
    stuck = 0;
    exp_fail = '0;
    exp_spur = 0;
    exp_order.delete();
    exp_done = 0;
    for (int t = 0; t < NT; t++) begin
      exp_inj[t] = 0;
      if (!stuck && mask[t]) begin
        exp_order.push_back(t);
        ack_ok = (ack_lat[t] >= 0) && (ack_lat[t] < w);
        inj = ack_ok ? ack_lat[t] + 1 : w;
        exp_inj[t] = inj;
        det_ok = 0; wt = 0; spur = 0;
        if (ack_ok) begin
          det_ok = (det_lat[t] >= 0) && (det_lat[t] < w);
          wt = det_ok ? det_lat[t] + 1 : w;
          spur = spur_en[t];
        end
        if (!det_ok) exp_fail[t] = 1'b1;
        if (spur) exp_spur = 1;
        if (!(det_ok || spur)) cl = 1;
        else if (clr_lat[t] >= 0 && clr_lat[t] < w) cl = clr_lat[t] + 1;
        else begin
          cl = w;
          exp_fail[t] = 1'b1;
          stuck = 1;
          exp_done = cursor + inj + wt + cl + 1;
        end
        if (!stuck) cursor += inj + wt + cl + 2;
      end
    end
    if (!stuck) exp_done = cursor + 1;
  endtask

  // Monitors and injector as seen from the bench, evaluated once per cycle at
  // the falling edge after the DUT's Moore outputs have settled.
  task automatic responderStep();
    int t;
    if (clr_err_o) begin
      waiting = 0;
      clr_cnt++;
      if (clr_lat[cur_t] >= 0 && clr_cnt - 1 >= clr_lat[cur_t]) flags = '0;
    end else begin
      clr_cnt = 0;
    end
    if (waiting) begin
      if (wcnt == 0 && spur_en[cur_t]) flags[(cur_t + 1) % NT] = 1'b1;
      if (wcnt == det_lat[cur_t]) flags[cur_t] = 1'b1;
      wcnt++;
    end
    if (inj_req_o) begin
      t = selIdx(inj_sel_o);
      if (req_cnt == 0) order.push_back(t);
      req_cnt++;
      if (t >= 0) begin
        req_cycles[t]++;
        cur_t = t;
      end
      if (t >= 0 && ack_lat[t] >= 0 && req_cnt - 1 >= ack_lat[t]) begin
        inj_ack_i = 1'b1;
        waiting = 1;
        wcnt = 0;
      end else begin
        inj_ack_i = 1'b0;
      end
    end else begin
      req_cnt = 0;
      inj_ack_i = 1'b0;
      if (inj_sel_o != '0) sel_errs++;
    end
    err_detect_i = flags;
  endtask

  task automatic applyStimulus(input logic [NT-1:0] mask, input int tmo);
    flags = '0; waiting = 0; wcnt = 0; req_cnt = 0; clr_cnt = 0; cur_t = 0;
    order.delete();
    for (int t = 0; t < NT; t++) req_cycles[t] = 0;
    sel_errs = 0; done_cyc = -1; abort_cyc = -1;
    @(negedge clk_i);
    target_mask_i = mask;
    timeout_i = TW'(tmo);
    start_i = 1'b1;
    abort_i = 1'b0;
    inj_ack_i = 1'b0;
    err_detect_i = '0;
    @(posedge clk_i);
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      abort_i = 1'b0;
      if (cyc == 1) checkOutput("busy_at_select", 32'(busy_o), 1);
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      responderStep();
      if (cyc == glitch_cyc) begin
        start_i = 1'b1;
        target_mask_i = ~mask;
        timeout_i = TW'(1);
      end
      if (abort_tgt >= 0 && waiting && cur_t == abort_tgt && wcnt == 2 && abort_cyc < 0) begin
        abort_i = 1'b1;
        abort_cyc = cyc;
      end
    end
    total++;
    assert (done_cyc >= 0) else begin
      bad++;
      $error("[TB] FAIL done_wait: observed=no_done expected=done_within_budget");
    end
  endtask

  task automatic checkCampaign(input string tag, input logic [NT-1:0] mask);
    checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    checkOutput({tag, "_busy"}, 32'(busy_o), 0);
    checkOutput({tag, "_fail_vec"}, 32'(fail_vec_o), 32'(exp_fail));
    checkOutput({tag, "_pass"}, 32'(pass_o), 32'(exp_fail == '0));
    checkOutput({tag, "_spurious"}, 32'(spurious_o), 32'(exp_spur));
    checkOutput({tag, "_aborted"}, 32'(aborted_o), 0);
    checkOutput({tag, "_req_low"}, 32'(inj_req_o), 0);
    checkOutput({tag, "_clr_low"}, 32'(clr_err_o), 0);
    checkOutput({tag, "_sel_idle"}, 32'(sel_errs), 0);
    checkOutput({tag, "_order_len"}, 32'(order.size()), 32'(exp_order.size()));
    for (int i = 0; i < exp_order.size(); i++) begin
      checkOutput({tag, "_order"}, (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF,
                  32'(exp_order[i]));
    end
    for (int t = 0; t < NT; t++) begin
      if (mask[t]) checkOutput({tag, "_inj_cycles"}, 32'(req_cycles[t]), 32'(exp_inj[t]));
    end
  endtask

  initial begin
    int tmo;
    logic [NT-1:0] mask;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; inj_ack_i = 1'b0;
    err_detect_i = '0; target_mask_i = '0; timeout_i = '0;
    setAll(0, 0, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkAllZero("reset");
    rst_i = 1'b0;

    // Full campaign, responses one cycle late; a start pulse mid-run is ignored.
    setAll(1, 1, 1);
    glitch_cyc = 3;
    modelCampaign(3'b111, 8);
    applyStimulus(3'b111, 8);
    checkCampaign("all_pass", 3'b111);

    // Single target with immediate responses.
    setAll(0, 0, 0);
    modelCampaign(3'b001, 3);
    applyStimulus(3'b001, 3);
    checkCampaign("single", 3'b001);
    checkOutput("single_done_at_7", 32'(done_cyc), 7);

    // ECC never flags.
    setAll(0, 0, 0);
    det_lat[TGT_ECC] = -1;
    modelCampaign(3'b010, 4);
    applyStimulus(3'b010, 4);
    checkCampaign("ecc_miss", 3'b010);
    checkOutput("ecc_miss_fail_vec", 32'(fail_vec_o), 32'b010);

    // Watchdog injector never acks.
    setAll(0, 0, 0);
    ack_lat[TGT_WATCHDOG] = -1;
    modelCampaign(3'b101, 5);
    applyStimulus(3'b101, 5);
    checkCampaign("wdog_noack", 3'b101);
    checkOutput("wdog_inject_cycles", 32'(req_cycles[TGT_WATCHDOG]), 5);
    checkOutput("wdog_fail_vec", 32'(fail_vec_o), 32'b100);

    // Reset in DONE clears the sticky verdicts.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkAllZero("rst_done");
    rst_i = 1'b0;

    // Abort during the ECC detect window.
    setAll(0, 0, 0);
    det_lat[TGT_ECC] = -1;
    abort_tgt = TGT_ECC;
    applyStimulus(3'b111, 8);
    checkOutput("abort_seen", 32'(abort_cyc > 0), 1);
    checkOutput("abort_done_next", 32'(done_cyc), 32'(abort_cyc + 1));
    checkOutput("abort_aborted", 32'(aborted_o), 1);
    checkOutput("abort_req", 32'(inj_req_o), 0);
    checkOutput("abort_clr", 32'(clr_err_o), 0);
    checkOutput("abort_fail_vec", 32'(fail_vec_o), 0);
    checkOutput("abort_pass", 32'(pass_o), 0);

    // Detect coincides with window expiry; detect wins.
    setAll(0, 0, 0);
    modelCampaign(3'b001, 1);
    applyStimulus(3'b001, 1);
    checkCampaign("det_vs_expiry", 3'b001);
    checkOutput("det_vs_expiry_pass", 32'(pass_o), 1);

    // ECC flag raised during the lockstep test.
    setAll(0, 0, 0);
    spur_en[TGT_LOCKSTEP] = 1'b1;
    modelCampaign(3'b001, 4);
    applyStimulus(3'b001, 4);
    checkCampaign("spurious", 3'b001);
    checkOutput("spurious_flag", 32'(spurious_o), 1);
    checkOutput("spurious_verdict", 32'(fail_vec_o), 0);

    // Empty mask.
    setAll(0, 0, 0);
    modelCampaign(3'b000, 4);
    applyStimulus(3'b000, 4);
    checkCampaign("empty", 3'b000);
    checkOutput("empty_done_at_2", 32'(done_cyc), 2);

    // Reset while in INJECT.
    setAll(-1, 0, 0);
    @(negedge clk_i);
    target_mask_i = 3'b001; timeout_i = TW'(8); start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rst_mid_req_before", 32'(inj_req_o), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkAllZero("rst_mid");
    rst_i = 1'b0;

    // Randomized campaigns, including zero timeout and stuck clears.
    for (int k = 0; k < 25; k++) begin
      tmo = $urandom_range(0, 6);
      mask = NT'($urandom_range(0, 7));
      setAll(0, 0, 0);
      for (int t = 0; t < NT; t++) begin
        ack_lat[t] = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, tmo + 1);
        det_lat[t] = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, tmo + 1);
        clr_lat[t] = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, tmo + 1);
        spur_en[t] = ($urandom_range(0, 5) == 0);
      end
      modelCampaign(mask, tmo);
      applyStimulus(mask, tmo);
      checkCampaign("random", mask);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
